// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the one-hot register file and other consumers of
// the 5:32 write-select decoder.
//   DATA_WIDTH / NUM_REGS / SEL_WIDTH / ZERO_REG : default geometry
//   reg_word_t                                    : one register word
//   onehot_to_index()                             : {valid, index} for a NUM_REGS-bit vector
package regfile_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned SEL_WIDTH  = 5;
    localparam int unsigned ZERO_REG   = 31;

    typedef logic [DATA_WIDTH-1:0] reg_word_t;

    typedef struct packed {
        logic                 valid;
        logic [SEL_WIDTH-1:0] index;
    } onehot_idx_t;

    // valid is set only for exactly one hot bit; index is meaningful only when valid.
    function automatic onehot_idx_t onehot_to_index(input logic [NUM_REGS-1:0] vec);
        onehot_idx_t res;
        res.valid = (vec != '0) && ((vec & (vec - NUM_REGS'(1))) == '0);
        res.index = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (vec[i]) begin
                res.index = res.index | SEL_WIDTH'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/onehot_check.sv
// Classifies a write-select vector.
//   vec       in  : candidate one-hot vector
//   is_zero   out : no bit set
//   is_onehot out : exactly one bit set
//   index     out : position of the set bit (only meaningful when is_onehot)
module onehot_check
    import regfile_pkg::*;
#(
    parameter int unsigned VEC_WIDTH = NUM_REGS,
    parameter int unsigned IDX_WIDTH = SEL_WIDTH
) (
    input  logic [VEC_WIDTH-1:0] vec,
    output logic                 is_zero,
    output logic                 is_onehot,
    output logic [IDX_WIDTH-1:0] index
);

    always_comb begin
        is_zero   = (vec == '0);
        // Clearing the lowest set bit leaves zero only for a single-bit vector.
        is_onehot = !is_zero && ((vec & (vec - VEC_WIDTH'(1))) == '0);
        // OR of set-bit positions equals the position when exactly one bit is set.
        index     = '0;
        for (int i = 0; i < VEC_WIDTH; i++) begin
            if (vec[i]) begin
                index = index | IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_register_file.sv
// 32-entry register file fed by a one-hot write-enable vector.
//   clk, reset              : clock, synchronous active-high reset
//   write_onehot            : one-hot write enable, all-zero = no write
//   write_data              : data stored into the selected register
//   read_sel_a / read_sel_b : read port indices
//   read_data_a/read_data_b : combinational read data (ZERO_REG reads 0)
//   onehot_error            : sticky, set on any multi-hot write vector
//   write_count             : committed writes since reset, wraps at 16 bits
module onehot_register_file #(
    parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int unsigned NUM_REGS   = regfile_pkg::NUM_REGS,
    parameter int unsigned SEL_WIDTH  = regfile_pkg::SEL_WIDTH,
    parameter int unsigned ZERO_REG   = regfile_pkg::ZERO_REG,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REGS-1:0]   write_onehot,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [SEL_WIDTH-1:0]  read_sel_a,
    input  logic [SEL_WIDTH-1:0]  read_sel_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic                  onehot_error,
    output logic [15:0]           write_count
);

    localparam logic [SEL_WIDTH-1:0] ZeroIdx = SEL_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  error_q;
    logic [15:0]           count_q;

    logic                  wr_is_zero;
    logic                  wr_is_onehot;
    logic [SEL_WIDTH-1:0]  wr_idx;
    logic                  bypass_ok;

    onehot_check #(
        .VEC_WIDTH (NUM_REGS),
        .IDX_WIDTH (SEL_WIDTH)
    ) u_onehot_check (
        .vec       (write_onehot),
        .is_zero   (wr_is_zero),
        .is_onehot (wr_is_onehot),
        .index     (wr_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            error_q <= 1'b0;
            count_q <= '0;
        end else if (wr_is_onehot) begin
            // A write aimed at the zero register still counts as committed.
            if (wr_idx != ZeroIdx) begin
                regs_q[wr_idx] <= write_data;
            end
            count_q <= count_q + 16'd1;
        end else if (!wr_is_zero) begin
            error_q <= 1'b1;
        end
    end

    // Forwarding is suppressed under reset because the write is discarded on that edge.
    assign bypass_ok = (BYPASS != 0) && wr_is_onehot && !reset && (wr_idx != ZeroIdx);

    always_comb begin
        read_data_a = regs_q[read_sel_a];
        if (bypass_ok && (wr_idx == read_sel_a)) begin
            read_data_a = write_data;
        end
        if (read_sel_a == ZeroIdx) begin
            read_data_a = '0;
        end

        read_data_b = regs_q[read_sel_b];
        if (bypass_ok && (wr_idx == read_sel_b)) begin
            read_data_b = write_data;
        end
        if (read_sel_b == ZeroIdx) begin
            read_data_b = '0;
        end
    end

    assign onehot_error = error_q;
    assign write_count  = count_q;

endmodule
